// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed radix-2 DIF FFT output pairs into natural bin order.
// Two ping-pong frame buffers, each split into LO/HI banks; one word per beat out.
//
// Per-buffer state | meaning
//   S_EMPTY        | free, may become the write target
//   S_FILL         | partially written by the input side
//   S_FULL         | whole frame written, waiting for the read side
//   S_DRAIN        | reads issued, waiting for bin N-1 to leave the output
module fft_bitrev_reorder #(
  parameter int BW    = 16,
  parameter int LOG2N = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [BW-1:0]    i_in_real0,
  input  logic [BW-1:0]    i_in_imag0,
  input  logic [BW-1:0]    i_in_real1,
  input  logic [BW-1:0]    i_in_imag1,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [BW-1:0]    o_out_real,
  output logic [BW-1:0]    o_out_imag,
  output logic [LOG2N-1:0] o_out_index,
  output logic             o_out_last
);

  localparam int N  = 1 << LOG2N;
  localparam int H  = N / 2;
  localparam int AW = LOG2N - 1;
  localparam int DW = 2 * BW;

  typedef enum logic [1:0] {S_EMPTY, S_FILL, S_FULL, S_DRAIN} buf_state_t;

  function automatic logic [AW-1:0] f_bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] v;
    for (int i = 0; i < AW; i++) v[i] = a[AW-1-i];
    return v;
  endfunction

  buf_state_t       r_state     [2];
  buf_state_t       w_state_nxt [2];

  logic             r_wptr, r_rptr, r_dptr;
  logic [AW-1:0]    r_wcnt;
  logic [LOG2N-1:0] r_rcnt;

  logic [DW-1:0]    r_mem_lo [0:2*H-1];
  logic [DW-1:0]    r_mem_hi [0:2*H-1];

  logic             r_rd_vld;
  logic [DW-1:0]    r_rd_data;
  logic [LOG2N-1:0] r_rd_idx;

  logic             r_out_vld;
  logic [DW-1:0]    r_out_data;
  logic [LOG2N-1:0] r_out_idx;

  logic             r_skid_vld;
  logic [DW-1:0]    r_skid_data;
  logic [LOG2N-1:0] r_skid_idx;

  logic             w_wr, w_wr_last, w_rd_avail, w_rd_issue, w_rd_last, w_pop, w_out_last;
  logic [AW-1:0]    w_waddr;
  logic [1:0]       w_occ;

  assign o_in_ready = !i_rst && (r_state[r_wptr] == S_EMPTY || r_state[r_wptr] == S_FILL);
  assign w_wr       = i_in_valid && o_in_ready;
  assign w_wr_last  = (r_wcnt == AW'(H-1));
  assign w_waddr    = f_bitrev(r_wcnt);

  // Words already committed downstream (RAM output + output reg + skid) must
  // still fit in the two output slots once this cycle's pop is accounted for.
  assign w_pop      = r_out_vld && i_out_ready;
  assign w_occ      = {1'b0, r_out_vld} + {1'b0, r_skid_vld} + {1'b0, r_rd_vld};
  assign w_rd_avail = (r_state[r_rptr] == S_FULL) || (r_state[r_rptr] == S_DRAIN);
  assign w_rd_issue = w_rd_avail && (w_occ <= (2'd1 + {1'b0, w_pop}));
  assign w_rd_last  = (r_rcnt == LOG2N'(N-1));
  assign w_out_last = (r_out_idx == LOG2N'(N-1));

  assign o_out_valid = r_out_vld;
  assign o_out_real  = r_out_data[DW-1:BW];
  assign o_out_imag  = r_out_data[BW-1:0];
  assign o_out_index = r_out_idx;
  assign o_out_last  = r_out_vld && w_out_last;

  always_comb begin
    w_state_nxt = r_state;
    for (int i = 0; i < 2; i++) begin
      case (r_state[i])
        S_EMPTY: if (w_wr && r_wptr == 1'(i))
                   w_state_nxt[i] = w_wr_last ? S_FULL : S_FILL;
        S_FILL:  if (w_wr && r_wptr == 1'(i) && w_wr_last)
                   w_state_nxt[i] = S_FULL;
        S_FULL:  if (w_rd_issue && r_rptr == 1'(i))
                   w_state_nxt[i] = S_DRAIN;
        S_DRAIN: if (w_pop && w_out_last && r_dptr == 1'(i))
                   w_state_nxt[i] = S_EMPTY;
        default: w_state_nxt[i] = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem_lo[{r_wptr, w_waddr}] <= {i_in_real0, i_in_imag0};
      r_mem_hi[{r_wptr, w_waddr}] <= {i_in_real1, i_in_imag1};
    end
    if (w_rd_issue)
      r_rd_data <= r_rcnt[AW] ? r_mem_hi[{r_rptr, r_rcnt[AW-1:0]}]
                              : r_mem_lo[{r_rptr, r_rcnt[AW-1:0]}];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= '{S_EMPTY, S_EMPTY};
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_dptr      <= 1'b0;
      r_wcnt      <= '0;
      r_rcnt      <= '0;
      r_rd_vld    <= 1'b0;
      r_rd_idx    <= '0;
      r_out_vld   <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_skid_vld  <= 1'b0;
      r_skid_data <= '0;
      r_skid_idx  <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_wr) begin
        r_wcnt <= r_wcnt + 1'b1;
        if (w_wr_last) r_wptr <= ~r_wptr;
      end

      r_rd_vld <= w_rd_issue;
      if (w_rd_issue) begin
        r_rd_idx <= r_rcnt;
        r_rcnt   <= r_rcnt + 1'b1;
        if (w_rd_last) r_rptr <= ~r_rptr;
      end

      if (w_pop && w_out_last) r_dptr <= ~r_dptr;

      // Output reg is the head of a 2-deep queue; the skid only fills on a stall.
      if (!r_out_vld || w_pop) begin
        if (r_skid_vld) begin
          r_out_vld   <= 1'b1;
          r_out_data  <= r_skid_data;
          r_out_idx   <= r_skid_idx;
          r_skid_vld  <= r_rd_vld;
          r_skid_data <= r_rd_data;
          r_skid_idx  <= r_rd_idx;
        end else if (r_rd_vld) begin
          r_out_vld  <= 1'b1;
          r_out_data <= r_rd_data;
          r_out_idx  <= r_rd_idx;
        end else begin
          r_out_vld <= 1'b0;
        end
      end else if (r_rd_vld) begin
        r_skid_vld  <= 1'b1;
        r_skid_data <= r_rd_data;
        r_skid_idx  <= r_rd_idx;
      end
    end
  end

endmodule
